// File: rtl/friscv_dpram.sv
// rtl/friscv_dpram.sv - dual-port RAM, write on both ports, async or registered read
module friscv_dpram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int FFD_EN     = 0,
    parameter int INIT       = 0
) (
    input  logic                  aclk,
    input  logic                  p1_wren,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_data_in,
    output logic [DATA_WIDTH-1:0] p1_data_out,
    input  logic                  p2_wren,
    input  logic [ADDR_WIDTH-1:0] p2_addr,
    input  logic [DATA_WIDTH-1:0] p2_data_in,
    output logic [DATA_WIDTH-1:0] p2_data_out
);

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

    // Contents are never preloaded; INIT is kept so callers can pass it.
    logic unused_init;
    assign unused_init = (INIT != 0);

    // Same-address double write: port 2 wins.
    always_ff @(posedge aclk) begin
        if (p1_wren) begin
            mem[p1_addr] <= p1_data_in;
        end
        if (p2_wren) begin
            mem[p2_addr] <= p2_data_in;
        end
    end

    generate
        if (FFD_EN != 0) begin : g_ffd_read
            always_ff @(posedge aclk) begin
                p1_data_out <= mem[p1_addr];
                p2_data_out <= mem[p2_addr];
            end
        end else begin : g_async_read
            assign p1_data_out = mem[p1_addr];
            assign p2_data_out = mem[p2_addr];
        end
    endgenerate

endmodule

// File: rtl/friscv_scfifo.sv
// rtl/friscv_scfifo.sv - single-clock valid/ready FIFO over friscv_dpram
module friscv_scfifo #(
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int AFULL_THRESH  = 2**ADDR_WIDTH-1,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  afull,
    output logic                  aempty
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] unused_p1_data;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Wrap bit keeps full and empty distinct when the indexes coincide.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                   (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
    assign count = wr_ptr - rd_ptr;

    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign afull     = (int'(count) >= AFULL_THRESH) || (count == DEPTH_W && AFULL_THRESH > DEPTH);
    assign aempty    = (int'(count) <= AEMPTY_THRESH);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    friscv_dpram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .FFD_EN     (0),
        .INIT       (0)
    ) u_ram (
        .aclk        (aclk),
        .p1_wren     (push),
        .p1_addr     (wr_ptr[ADDR_WIDTH-1:0]),
        .p1_data_in  (in_data),
        .p1_data_out (unused_p1_data),
        .p2_wren     (1'b0),
        .p2_addr     (rd_ptr[ADDR_WIDTH-1:0]),
        .p2_data_in  ({DATA_WIDTH{1'b0}}),
        .p2_data_out (out_data)
    );

endmodule

// File: tb/tb_friscv_scfifo.sv
// tb/tb_friscv_scfifo.sv - self-checking bench for friscv_scfifo
module tb_friscv_scfifo;

    localparam int AW    = 2;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          afull;
    logic          aempty;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] q[$];

    always #5 aclk = ~aclk;

    friscv_scfifo #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .AFULL_THRESH  (3),
        .AEMPTY_THRESH (1)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .afull     (afull),
        .aempty    (aempty)
    );

    typedef struct {
        logic          f;
        logic          v;
        logic [DW-1:0] d;
        logic          r;
        int            e_count;
        logic          e_full;
        logic          e_empty;
        logic          e_afull;
        logic          e_aempty;
        logic [DW-1:0] e_data;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        int n;
        n = q.size();
        chk("m_count", int'(count), n);
        chk("m_full", int'(full), int'(n == DEPTH));
        chk("m_empty", int'(empty), int'(n == 0));
        chk("m_afull", int'(afull), int'(n >= 3));
        chk("m_aempty", int'(aempty), int'(n <= 1));
        chk("m_in_ready", int'(in_ready), int'(n != DEPTH));
        chk("m_out_valid", int'(out_valid), int'(n != 0));
        if (n != 0) chk("m_out_data", int'(out_data), int'(q[0]));
    endtask

    // Applies inputs for one cycle, checks the pre-edge outputs, advances the model.
    task automatic drive(input logic f, input logic v, input logic [DW-1:0] d, input logic r);
        int n;
        @(negedge aclk);
        flush = f; in_valid = v; in_data = d; out_ready = r;
        check_model();
        n = q.size();
        if (f) begin
            q.delete();
        end else begin
            if (r && n > 0) void'(q.pop_front());
            if (v && n < DEPTH) q.push_back(d);
        end
    endtask

    vec_t vecs[10];

    initial begin
        aresetn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(negedge aclk);
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_afull", int'(afull), 0);
        chk("rst_aempty", int'(aempty), 1);
        aresetn = 1'b1;

        // Fill past full, drain; also walks the thresholds up and back down.
        vecs[0] = '{1'b0, 1'b1, 8'h10, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00};
        vecs[1] = '{1'b0, 1'b1, 8'h11, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h10};
        vecs[2] = '{1'b0, 1'b1, 8'h12, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h10};
        vecs[3] = '{1'b0, 1'b1, 8'h13, 1'b0, 3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h10};
        vecs[4] = '{1'b0, 1'b1, 8'h14, 1'b0, 4, 1'b1, 1'b0, 1'b1, 1'b0, 8'h10};
        vecs[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 4, 1'b1, 1'b0, 1'b1, 1'b0, 8'h10};
        vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11};
        vecs[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h12};
        vecs[8] = '{1'b0, 1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h13};
        vecs[9] = '{1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00};
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].f, vecs[i].v, vecs[i].d, vecs[i].r);
            chk("t_count", int'(count), vecs[i].e_count);
            chk("t_full", int'(full), int'(vecs[i].e_full));
            chk("t_empty", int'(empty), int'(vecs[i].e_empty));
            chk("t_afull", int'(afull), int'(vecs[i].e_afull));
            chk("t_aempty", int'(aempty), int'(vecs[i].e_aempty));
            chk("t_in_ready", int'(in_ready), int'(!vecs[i].e_full));
            if (!vecs[i].e_empty) chk("t_out_data", int'(out_data), int'(vecs[i].e_data));
        end

        // Index wrap: offset the pointers, then fill completely.
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 8'(8'h30 + i), 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 8'(8'hA0 + i), 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("wrap_count", int'(count), 4);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b1);
            chk("wrap_data", int'(out_data), 8'hA0 + i);
        end

        // Concurrent push and pop at count 2.
        drive(1'b0, 1'b1, 8'h00, 1'b0);
        drive(1'b0, 1'b1, 8'h01, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 8'(i + 2), 1'b1);
            chk("conc_count", int'(count), 2);
            chk("conc_data", int'(out_data), i);
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("conc_end_count", int'(count), 2);

        // Flush wins over push and pop at count 3.
        drive(1'b0, 1'b1, 8'h40, 1'b0);
        drive(1'b0, 1'b1, 8'h77, 1'b1);
        chk("pre_flush_count", int'(count), 3);
        drive(1'b1, 1'b1, 8'h78, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("flush_count", int'(count), 0);
        chk("flush_empty", int'(empty), 1);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("flush_out_valid", int'(out_valid), 0);

        // Asynchronous reset between edges at count 2.
        drive(1'b0, 1'b1, 8'h21, 1'b0);
        drive(1'b0, 1'b1, 8'h22, 1'b0);
        @(negedge aclk);
        in_valid = 1'b0;
        chk("pre_rst_count", int'(count), 2);
        #2 aresetn = 1'b0;
        #1;
        chk("arst_count", int'(count), 0);
        chk("arst_empty", int'(empty), 1);
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_in_ready", int'(in_ready), 1);
        chk("arst_aempty", int'(aempty), 1);
        q.delete();
        @(negedge aclk);
        aresetn = 1'b1;
        drive(1'b0, 1'b1, 8'h55, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("post_rst_data", int'(out_data), 8'h55);
        chk("post_rst_count", int'(count), 1);

        // Random traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 31) == 0), 1'($urandom), 8'($urandom), 1'($urandom));
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
